fifo_packetizer: RTL

Drains the single-clock byte FIFO from its read side and emits framed packets on a valid/ready byte stream. A packet is sent once the FIFO holds MAX_LEN bytes, or after the FIFO has been non-empty for TIMEOUT idle cycles. The block sits directly downstream of the FIFO: it drives the FIFO's read enable and consumes its registered read data, empty flag and occupancy count.

---
 rtl/fifo_packetizer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_packetizer
// Description : Drains a single-clock byte FIFO and emits framed packets on a
//               valid/ready byte stream:
//                   SOF_BYTE, LEN, LEN payload bytes, CSUM
//               where LEN + payload + CSUM == 0 (mod 256). A packet is sent
//               when the FIFO holds MAX_LEN bytes, or as a short packet after
//               the FIFO has been non-empty for TIMEOUT idle cycles.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               fifo_data  - FIFO registered read data (valid after rd_en)
//               fifo_empty - FIFO empty flag
//               fifo_count - FIFO occupancy, 0..64
//               fifo_rd_en - FIFO read strobe, one cycle per payload byte
//               out_data   - stream byte
//               out_valid  - stream byte valid
//               out_ready  - sink accepts the byte this cycle
//               out_sof    - marks the header byte
//               out_eof    - marks the checksum byte
//               busy       - high outside IDLE
//               pkt_count  - completed packets, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_packetizer #(
    parameter int         MAX_LEN  = 16,
    parameter int         TIMEOUT  = 32,
    parameter logic [7:0] SOF_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_count,
    output logic        fifo_rd_en,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam int         c_IDLE_W   = $clog2(TIMEOUT);
    localparam logic [7:0] c_MAX_LEN8 = 8'(MAX_LEN);
    localparam logic [6:0] c_MAX_LEN7 = 7'(MAX_LEN);
    localparam logic [c_IDLE_W-1:0] c_TO_LAST = c_IDLE_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HDR  = 3'd1;
    localparam logic [2:0] c_ST_LEN  = 3'd2;
    localparam logic [2:0] c_ST_RD   = 3'd3;
    localparam logic [2:0] c_ST_DATA = 3'd4;
    localparam logic [2:0] c_ST_CSUM = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [6:0]          r_len;
    logic [6:0]          r_remaining;
    logic [7:0]          r_csum;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [15:0]         r_pkt_count;
    logic                w_hs;

    // The read length never exceeds the occupancy snapshot and there is no
    // other reader, so the empty flag carries no information for this block.
    logic w_unused_empty;
    assign w_unused_empty = fifo_empty;

    assign w_hs      = out_valid && out_ready;
    assign pkt_count = r_pkt_count;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (fifo_count >= c_MAX_LEN8) begin
                    w_next = c_ST_HDR;
                end else if ((fifo_count != 8'd0) && (r_idle_cnt == c_TO_LAST)) begin
                    w_next = c_ST_HDR;
                end
            end
            c_ST_HDR:  if (w_hs) w_next = c_ST_LEN;
            c_ST_LEN:  if (w_hs) w_next = c_ST_RD;
            c_ST_RD:   w_next = c_ST_DATA;
            c_ST_DATA: begin
                if (w_hs) begin
                    w_next = (r_remaining == 7'd1) ? c_ST_CSUM : c_ST_RD;
                end
            end
            c_ST_CSUM: if (w_hs) w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state; in DATA the byte comes
    // straight from the FIFO's output register, which holds until the next read.
    always_comb begin
        fifo_rd_en = 1'b0;
        out_data   = 8'd0;
        out_valid  = 1'b0;
        out_sof    = 1'b0;
        out_eof    = 1'b0;
        busy       = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_HDR: begin
                out_data  = SOF_BYTE;
                out_sof   = 1'b1;
                out_valid = 1'b1;
            end
            c_ST_LEN: begin
                out_data  = {1'b0, r_len};
                out_valid = 1'b1;
            end
            c_ST_RD: begin
                fifo_rd_en = 1'b1;
            end
            c_ST_DATA: begin
                out_data  = fifo_data;
                out_valid = 1'b1;
            end
            c_ST_CSUM: begin
                out_data  = 8'd0 - r_csum;
                out_eof   = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: length snapshot, idle timer, running checksum, packet counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len       <= 7'd0;
            r_remaining <= 7'd0;
            r_csum      <= 8'd0;
            r_idle_cnt  <= '0;
            r_pkt_count <= 16'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (fifo_count >= c_MAX_LEN8) begin
                        r_len      <= c_MAX_LEN7;
                        r_idle_cnt <= '0;
                    end else if (fifo_count != 8'd0) begin
                        if (r_idle_cnt == c_TO_LAST) begin
                            // Below MAX_LEN here, so the count fits in 7 bits
                            r_len      <= fifo_count[6:0];
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end
                c_ST_HDR: begin
                    if (w_hs) begin
                        r_csum      <= 8'd0;
                        r_remaining <= r_len;
                    end
                end
                c_ST_LEN: begin
                    if (w_hs) r_csum <= r_csum + {1'b0, r_len};
                end
                c_ST_DATA: begin
                    if (w_hs) begin
                        r_csum      <= r_csum + fifo_data;
                        r_remaining <= r_remaining - 7'd1;
                    end
                end
                c_ST_CSUM: begin
                    if (w_hs) r_pkt_count <= r_pkt_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
